menu_text_buf: RTL and testbench
================================

Name: menu_text_buf

Overview:
- Writable, multi-page character buffer for the text overlay.
- The glyph renderer reads it through the same 2-D character index it already uses, and gets a registered 7-bit char_code after one cycle.
- Game and menu logic write text at run time through a cursor-based put port. A clear engine fills a page with SPACE.
- The display page is selectable, so one page can be shown while another is composed.

Parameters:
- COLS, 16, characters per row.
- ROWS, 16, rows per page.
- PAGES, 2, number of independent pages.
- Derived localparams:
  - COL_W = $clog2(COLS)
  - ROW_W = $clog2(ROWS)
  - PG_W = max(1, $clog2(PAGES))
  - XY_W = ROW_W + COL_W

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- char_xy  in  XY_W  read index, {row, col}.
- disp_page  in  PG_W  page read by the renderer.
- char_code  out  7  registered character code.
- cur_set  in  1  load cursor.
- cur_page  in  PG_W  cursor page to load.
- cur_xy  in  XY_W  cursor {row, col} to load.
- put_valid  in  1  write request.
- put_char  in  7  character to write.
- put_ready  out  1  put accepted when put_valid && put_ready.
- clr_req  in  1  single-cycle clear command.
- clr_page  in  PG_W  page to clear.
- busy  out  1  clear in progress.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Storage: PAGES*ROWS*COLS x 7-bit RAM, addressed {page,row,col}. Synchronous write, synchronous read. The RAM array itself is not reset.
- Reset values (asserted while rst=1):
  - char_code = SPACE
  - put_ready = 0
  - busy = 1
  - cursor = page 0, (0,0)
  - FSM = CLR_ALL, clear counter = 0
- Read path:
  - char_code <= mem[disp_page, char_xy] each cycle; latency exactly 1 cycle.
  - Row >= ROWS, col >= COLS, or page >= PAGES returns SPACE.
  - When the read and a write hit the same cell in the same cycle, the read returns the old value.
  - Reads are never stalled, including during a clear.
- FSM states: CLR_ALL, IDLE, CLR_PAGE.
- CLR_ALL:
  - Entered from reset. Writes SPACE to one cell per cycle, linear index 0 .. PAGES*ROWS*COLS-1.
  - After the last cell, goes to IDLE.
  - Duration is PAGES*ROWS*COLS cycles after rst deasserts.
- IDLE:
  - busy = 0.
  - put_ready = !cur_set (cursor load has priority; a put in that cycle is not accepted).
  - cur_set loads cursor from cur_page/cur_xy. Out-of-range col or row is clamped to COLS-1 / ROWS-1.
  - On accepted put: mem[cursor] <= put_char, then the cursor advances:
    - col+1;
    - at col=COLS-1, col goes to 0 and row+1;
    - at the last cell, wraps to (0,0) of the same page (no page change).
  - clr_req moves to CLR_PAGE with counter 0. clr_req beats a same-cycle put: put_ready is forced to 0 that cycle.
- CLR_PAGE:
  - busy = 1, put_ready = 0.
  - Writes SPACE to clr_page (latched on entry) for cells 0 .. ROWS*COLS-1, one per cycle, then returns to IDLE.
  - Cursor is set to (clr_page, 0, 0) on completion.
- Ignored inputs while busy: clr_req and cur_set are dropped, not queued. put_valid stalls; the requester holds put_valid and put_char stable.
- Reset mid-operation: returns immediately to reset values and restarts CLR_ALL from index 0.
- Character codes (SPACE and the others) are 7-bit values taken from vga_pkg.

Decomposition:
- vga_pkg:
  - SPACE and the existing character constants.
  - New typedef text_state_t {CLR_ALL, IDLE, CLR_PAGE}.
- Sub-module text_ram: simple dual-port RAM, 1 write port plus 1 registered read port, parametrised on depth and width 7, inferable as BRAM/LUTRAM.
- menu_text_buf contains the FSM, cursor, clear counter, address muxing and range checks.

Test Plan:
1. Reset/init: pulse rst, then count busy-high cycles -> exactly 512 (defaults). Read char_xy=8'h3C on pages 0 and 1 -> SPACE, one cycle after address.
2. String write: cur_set page0 xy=8'h0E, then put 'U','E','C' back-to-back -> cells 0E,0F,10 hold U,E,C (row carry at 0F->10); the next put goes to 8'h11.
3. Wrap: cursor page1 xy=8'hFF, put 'A' -> mem[1,FF]=A, cursor = page1 8'h00. The page 0 cell is unchanged.
4. Page select: page0 8'h05='W', page1 8'h05='Z'. With char_xy=8'h05, toggling disp_page -> char_code follows with 1-cycle latency, W/Z.
5. Clear with contention: fill page0 and page1 cell 8'h20 with 'K', then clr_req page1 while put_valid is held with 'M'. Required response:
   - busy=1 for exactly 256 cycles and put_ready=0 throughout;
   - page1 reads SPACE, page0 8'h20 still reads 'K';
   - 'M' is accepted on the first IDLE cycle, at page1 8'h00.
6. Reset mid-clear: assert rst 40 cycles into a CLR_PAGE -> busy stays 1, and a fresh 512-cycle CLR_ALL runs. Then cur_set and put in the same IDLE cycle -> cursor loaded, put not accepted that cycle.

Source files
------------

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared character codes and text buffer state type
package vga_pkg;

    localparam logic [6:0] SPACE   = 7'h20;
    localparam logic [6:0] CH_ZERO = 7'h30;
    localparam logic [6:0] CH_A    = 7'h41;

    typedef enum logic [1:0] {
        CLR_ALL  = 2'd0,
        IDLE     = 2'd1,
        CLR_PAGE = 2'd2
    } text_state_t;

endpackage

// File: rtl/text_ram.sv
// rtl/text_ram.sv - simple dual-port RAM, one write port and one registered read port
module text_ram #(
    parameter int DEPTH = 512,
    parameter int AW    = $clog2(DEPTH),
    parameter int W     = 7
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    // Read-before-write: a same-cell read in the write cycle returns the old value.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/menu_text_buf.sv
// rtl/menu_text_buf.sv - multi-page overlay text buffer with cursor put port and page clear
module menu_text_buf
    import vga_pkg::*;
#(
    parameter int  COLS  = 16,
    parameter int  ROWS  = 16,
    parameter int  PAGES = 2,
    localparam int COL_W = $clog2(COLS),
    localparam int ROW_W = $clog2(ROWS),
    localparam int PG_W  = (PAGES > 1) ? $clog2(PAGES) : 1,
    localparam int XY_W  = ROW_W + COL_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XY_W-1:0] char_xy,
    input  logic [PG_W-1:0] disp_page,
    output logic [6:0]      char_code,
    input  logic            cur_set,
    input  logic [PG_W-1:0] cur_page,
    input  logic [XY_W-1:0] cur_xy,
    input  logic            put_valid,
    input  logic [6:0]      put_char,
    output logic            put_ready,
    input  logic            clr_req,
    input  logic [PG_W-1:0] clr_page,
    output logic            busy
);

    localparam int DEPTH = PAGES * ROWS * COLS;
    localparam int AW    = PG_W + XY_W;
    localparam int CNT_W = $clog2(DEPTH);

    text_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PG_W-1:0]  cpg_q, cpg_d;
    logic [ROW_W-1:0] crow_q, crow_d;
    logic [COL_W-1:0] ccol_q, ccol_d;
    logic [PG_W-1:0]  clrpg_q, clrpg_d;

    logic             we;
    logic [AW-1:0]    waddr;
    logic [6:0]       wdata;
    logic [ROW_W-1:0] set_row;
    logic [COL_W-1:0] set_col;
    logic             rd_ok, rd_ok_q;
    logic [6:0]       ram_q;

    function automatic logic page_ok(input logic [PG_W-1:0] pg);
        return int'(pg) < PAGES;
    endfunction

    always_comb begin
        set_row = cur_xy[XY_W-1:COL_W];
        set_col = cur_xy[COL_W-1:0];
        if (int'(set_row) >= ROWS) set_row = ROW_W'(ROWS - 1);
        if (int'(set_col) >= COLS) set_col = COL_W'(COLS - 1);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cpg_d     = cpg_q;
        crow_d    = crow_q;
        ccol_d    = ccol_q;
        clrpg_d   = clrpg_q;
        we        = 1'b0;
        waddr     = '0;
        wdata     = SPACE;
        put_ready = 1'b0;
        busy      = 1'b1;

        case (state_q)
            CLR_ALL: begin
                we    = 1'b1;
                waddr = AW'(cnt_q);
                if (cnt_q == CNT_W'(DEPTH - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            IDLE: begin
                busy      = 1'b0;
                put_ready = !cur_set && !clr_req;
                if (clr_req) begin
                    state_d = CLR_PAGE;
                    cnt_d   = '0;
                    clrpg_d = clr_page;
                end else if (cur_set) begin
                    cpg_d  = cur_page;
                    crow_d = set_row;
                    ccol_d = set_col;
                end else if (put_valid) begin
                    we    = page_ok(cpg_q);
                    waddr = {cpg_q, crow_q, ccol_q};
                    wdata = put_char;
                    // Cursor walks row-major and wraps within its own page.
                    if (ccol_q == COL_W'(COLS - 1)) begin
                        ccol_d = '0;
                        crow_d = (crow_q == ROW_W'(ROWS - 1)) ? '0 : crow_q + ROW_W'(1);
                    end else begin
                        ccol_d = ccol_q + COL_W'(1);
                    end
                end
            end

            CLR_PAGE: begin
                we    = page_ok(clrpg_q);
                waddr = {clrpg_q, cnt_q[XY_W-1:0]};
                if (cnt_q == CNT_W'(ROWS * COLS - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    cpg_d   = clrpg_q;
                    crow_d  = '0;
                    ccol_d  = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = CLR_ALL;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CLR_ALL;
            cnt_q   <= '0;
            cpg_q   <= '0;
            crow_q  <= '0;
            ccol_q  <= '0;
            clrpg_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cpg_q   <= cpg_d;
            crow_q  <= crow_d;
            ccol_q  <= ccol_d;
            clrpg_q <= clrpg_d;
        end
    end

    assign rd_ok = (int'(disp_page) < PAGES)
                && (int'(char_xy[XY_W-1:COL_W]) < ROWS)
                && (int'(char_xy[COL_W-1:0]) < COLS);

    // The RAM output register is not reset; the range flag masks it to SPACE instead.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ok_q <= 1'b0;
        end else begin
            rd_ok_q <= rd_ok;
        end
    end

    assign char_code = rd_ok_q ? ram_q : SPACE;

    text_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (7)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr ({disp_page, char_xy}),
        .rdata (ram_q)
    );

endmodule

// File: tb/tb_menu_text_buf.sv
// tb/tb_menu_text_buf.sv - scoreboard bench for menu_text_buf
module tb_menu_text_buf;
    import vga_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] char_xy = '0;
    logic [0:0] disp_page = '0;
    logic [6:0] char_code;
    logic       cur_set = 1'b0;
    logic [0:0] cur_page = '0;
    logic [7:0] cur_xy = '0;
    logic       put_valid = 1'b0;
    logic [6:0] put_char = '0;
    logic       put_ready;
    logic       clr_req = 1'b0;
    logic [0:0] clr_page = '0;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic [6:0] exp_q[$];
    string      tag_q[$];
    int         rd_pend = 0;

    always #5 clk = ~clk;

    menu_text_buf dut (
        .clk       (clk),
        .rst       (rst),
        .char_xy   (char_xy),
        .disp_page (disp_page),
        .char_code (char_code),
        .cur_set   (cur_set),
        .cur_page  (cur_page),
        .cur_xy    (cur_xy),
        .put_valid (put_valid),
        .put_char  (put_char),
        .put_ready (put_ready),
        .clr_req   (clr_req),
        .clr_page  (clr_page),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge; reads issued this cycle are scored there.
    task automatic cyc();
        int k;
        k = rd_pend;
        rd_pend = 0;
        @(negedge clk);
        repeat (k) chk(tag_q.pop_front(), char_code, exp_q.pop_front());
    endtask

    task automatic rd(input string tag, input logic [0:0] pg, input logic [7:0] xy, input logic [6:0] e);
        disp_page = pg;
        char_xy   = xy;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        rd_pend = 1;
    endtask

    task automatic set_cur(input logic [0:0] pg, input logic [7:0] xy);
        cur_set  = 1'b1;
        cur_page = pg;
        cur_xy   = xy;
        #1 chk("ready_on_cur_set", put_ready, 0);
        cyc();
        cur_set = 1'b0;
    endtask

    task automatic put(input logic [6:0] ch);
        int w;
        put_valid = 1'b1;
        put_char  = ch;
        w = 0;
        #1;
        while (!put_ready && w < 600) begin
            cyc();
            #1;
            w++;
        end
        if (!put_ready) chk("put_timeout", 0, 1);
        cyc();
        put_valid = 1'b0;
    endtask

    task automatic do_reset();
        int n;
        rst = 1'b1;
        #1;
        chk("rst_busy", busy, 1);
        chk("rst_put_ready", put_ready, 0);
        chk("rst_char_code", char_code, SPACE);
        cyc();
        rst = 1'b0;
        n = 0;
        while (busy && n < 2000) begin
            cyc();
            n++;
        end
        chk("clr_all_cycles", n, 512);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  ready_seen;

        // Reset and initial clear
        cyc();
        do_reset();
        rd("init_p0_3c", 1'b0, 8'h3C, SPACE); cyc();
        rd("init_p1_3c", 1'b1, 8'h3C, SPACE); cyc();

        // String across a row boundary
        set_cur(1'b0, 8'h0E);
        put(7'h55); put(7'h45); put(7'h43); put(7'h58);
        rd("str_0e", 1'b0, 8'h0E, 7'h55); cyc();
        rd("str_0f", 1'b0, 8'h0F, 7'h45); cyc();
        rd("str_10", 1'b0, 8'h10, 7'h43); cyc();
        rd("str_11", 1'b0, 8'h11, 7'h58); cyc();

        // Wrap at the last cell stays on the same page
        set_cur(1'b1, 8'hFF);
        put(CH_A); put(7'h42);
        rd("wrap_p1_ff", 1'b1, 8'hFF, CH_A); cyc();
        rd("wrap_p1_00", 1'b1, 8'h00, 7'h42); cyc();
        rd("wrap_p0_ff", 1'b0, 8'hFF, SPACE); cyc();

        // Page select with back-to-back reads
        set_cur(1'b0, 8'h05); put(7'h57);
        set_cur(1'b1, 8'h05); put(7'h5A);
        for (int i = 0; i < 6; i++) begin
            rd("page_sel", 1'(i % 2), 8'h05, (i % 2) ? 7'h5A : 7'h57);
            cyc();
        end

        // Clear page 1 while a put is held
        set_cur(1'b0, 8'h20); put(7'h4B);
        set_cur(1'b1, 8'h20); put(7'h4B);
        clr_req   = 1'b1;
        clr_page  = 1'b1;
        put_valid = 1'b1;
        put_char  = 7'h4D;
        #1 chk("ready_on_clr_req", put_ready, 0);
        cyc();
        clr_req = 1'b0;
        n = 0;
        ready_seen = 1'b0;
        while (busy && n < 1000) begin
            if (put_ready) ready_seen = 1'b1;
            cyc();
            n++;
        end
        chk("clr_page_cycles", n, 256);
        chk("ready_during_clr", ready_seen, 0);
        chk("ready_after_clr", put_ready, 1);
        cyc();
        put_valid = 1'b0;
        rd("clr_p1_00_m", 1'b1, 8'h00, 7'h4D); cyc();
        rd("clr_p1_20", 1'b1, 8'h20, SPACE); cyc();
        rd("clr_p1_05", 1'b1, 8'h05, SPACE); cyc();
        rd("clr_p1_01", 1'b1, 8'h01, SPACE); cyc();
        rd("clr_p0_20", 1'b0, 8'h20, 7'h4B); cyc();
        rd("clr_p0_05", 1'b0, 8'h05, 7'h57); cyc();

        // Reset in the middle of a page clear
        clr_req  = 1'b1;
        clr_page = 1'b0;
        cyc();
        clr_req = 1'b0;
        repeat (40) cyc();
        chk("mid_clr_busy", busy, 1);
        do_reset();
        rd("rst_p1_00", 1'b1, 8'h00, SPACE); cyc();
        rd("rst_p0_20", 1'b0, 8'h20, SPACE); cyc();

        // Cursor load beats a same-cycle put
        cur_set   = 1'b1;
        cur_page  = 1'b0;
        cur_xy    = 8'h30;
        put_valid = 1'b1;
        put_char  = 7'h51;
        #1 chk("ready_set_and_put", put_ready, 0);
        cyc();
        cur_set = 1'b0;
        #1 chk("ready_after_set", put_ready, 1);
        cyc();
        put_valid = 1'b0;
        rd("setput_p0_30", 1'b0, 8'h30, 7'h51); cyc();
        rd("setput_p0_00", 1'b0, 8'h00, SPACE); cyc();
        rd("setput_p0_31", 1'b0, 8'h31, SPACE); cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
